pcie_dma_mwr_ram_rd_ctrl: RTL

//  Upstream data source for the MWr TLP transmit controller. On each read request (i_rd_en / i_rd_length) it reads
//  the TLP payload from the 128-bit DMA buffer RAM and streams it as 128-bit beats, with valid (o_gen_tlp_start)
//  and last-beat (o_last_data) flags. A 2-entry skid FIFO absorbs the 1-cycle RAM read latency and back-pressure.
//  The read pointer advances across successive TLP chunks of one DMA, and reloads on i_dma_start.

---
 rtl/pcie_dma_mwr_ram_rd_ctrl_if.sv | 30 +++
 rtl/pcie_dma_mwr_ram_rd_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pcie_dma_mwr_ram_rd_ctrl_if.sv
// Payload read-side bundle between the MWr TX controller, the DMA buffer RAM and the read controller.
// master = TX controller / RAM side, slave = the read controller itself.
interface pcie_dma_mwr_ram_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  dma_start;
  logic [ADDR_WIDTH-1:0] buf_base_addr;
  logic                  rd_en;
  logic [9:0]            rd_length;
  logic                  mwr_tlp_tx;
  logic                  tx_hold;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [127:0]          ram_rd_data;
  logic                  gen_tlp_start;
  logic [127:0]          rd_data;
  logic                  last_data;
  logic                  rd_busy;
  logic                  err_start_busy;

  modport master (
    output dma_start, buf_base_addr, rd_en, rd_length, mwr_tlp_tx, tx_hold, ram_rd_data,
    input  ram_rd_en, ram_rd_addr, gen_tlp_start, rd_data, last_data, rd_busy, err_start_busy
  );

  modport slave (
    input  dma_start, buf_base_addr, rd_en, rd_length, mwr_tlp_tx, tx_hold, ram_rd_data,
    output ram_rd_en, ram_rd_addr, gen_tlp_start, rd_data, last_data, rd_busy, err_start_busy
  );
endinterface

// File: rtl/pcie_dma_mwr_ram_rd_ctrl.sv
// Streams one TLP payload from the 128-bit DMA buffer RAM as beats; first RAM read 1 cycle and first beat 2 cycles
// after rd_en is seen in IDLE. Back-pressure via mwr_tlp_tx/tx_hold is absorbed by a 2-entry fall-through skid FIFO.
module pcie_dma_mwr_ram_rd_ctrl #(
  parameter int ADDR_WIDTH = 9
) (
  input logic                     clk,
  input logic                     rst,
  pcie_dma_mwr_ram_rd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [8:0]            total;
  logic [8:0]            issued;
  logic [8:0]            popped;
  logic                  in_flight;
  logic                  err_start_busy_q;

  logic [127:0]          fifo_mem [0:1];
  logic                  fifo_wr_idx;
  logic                  fifo_rd_idx;
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;

  logic [10:0]           len_dw;
  logic [10:0]           len_round;
  logic [8:0]            total_nxt;
  logic                  head_vld;
  logic [127:0]          head_dat;
  logic                  head_last;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic                  last_pop;
  logic                  room;
  logic                  issue;
  logic                  abort;

  // A length field of 0 encodes the maximum 1024 DW payload.
  always_comb begin
    len_dw    = {(bus.rd_length == 10'd0), bus.rd_length};
    len_round = len_dw + 11'd3;
    total_nxt = len_round[10:2];
  end

  // The head falls through from the RAM when the FIFO is empty, so an unstalled stream costs no extra cycle.
  always_comb begin
    head_vld  = (occ != 2'd0) | in_flight;
    head_dat  = (occ != 2'd0) ? fifo_mem[fifo_rd_idx] : bus.ram_rd_data;
    head_last = head_vld & (popped == total - 9'd1);
    pop       = head_vld & bus.mwr_tlp_tx & ~bus.tx_hold;
    pop_fifo  = pop & (occ != 2'd0);
    push      = in_flight & ~(pop & (occ == 2'd0));
    last_pop  = pop & (popped == total - 9'd1);
    room      = (occ == 2'd0) | ((occ == 2'd1) & ~in_flight);
    issue     = (state == READ) & bus.rd_en & (issued < total) & room;
    abort     = (state == READ) & ~bus.rd_en & ~last_pop;
  end

  always_comb begin
    occ_nxt = occ;
    case ({push, pop_fifo})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.rd_en) state_nxt = READ;
      end
      READ: begin
        if (last_pop) begin
          state_nxt = WAIT_LOW;
        end else if (!bus.rd_en) begin
          state_nxt = IDLE;
        end
      end
      WAIT_LOW: begin
        // A level request that stays high after its TLP must not start another one.
        if (!bus.rd_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      rd_ptr           <= '0;
      total            <= '0;
      issued           <= '0;
      popped           <= '0;
      in_flight        <= 1'b0;
      occ              <= 2'd0;
      fifo_wr_idx      <= 1'b0;
      fifo_rd_idx      <= 1'b0;
      err_start_busy_q <= 1'b0;
    end else begin
      state            <= state_nxt;
      err_start_busy_q <= bus.dma_start & (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.dma_start) rd_ptr <= bus.buf_base_addr;
          if (bus.rd_en) begin
            total  <= total_nxt;
            issued <= '0;
            popped <= '0;
          end
        end
        READ: begin
          if (issue) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            issued <= issued + 9'd1;
          end
          if (pop) popped <= popped + 9'd1;
        end
        default: ;
      endcase
      // An aborted TLP leaves rd_ptr at the words actually issued; buffered and returning data is dropped.
      if (abort) begin
        in_flight   <= 1'b0;
        occ         <= 2'd0;
        fifo_wr_idx <= 1'b0;
        fifo_rd_idx <= 1'b0;
      end else begin
        in_flight <= issue;
        occ       <= occ_nxt;
        if (push)     fifo_wr_idx <= ~fifo_wr_idx;
        if (pop_fifo) fifo_rd_idx <= ~fifo_rd_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_idx] <= bus.ram_rd_data;
  end

  assign bus.ram_rd_en      = issue;
  assign bus.ram_rd_addr    = issue ? rd_ptr : '0;
  assign bus.gen_tlp_start  = head_vld;
  assign bus.rd_data        = head_vld ? head_dat : '0;
  assign bus.last_data      = head_last;
  assign bus.rd_busy        = (state != IDLE);
  assign bus.err_start_busy = err_start_busy_q;

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_fifo && occ == 2'd2));

endmodule
